dmem_mmio_responder: RTL and testbench
======================================

// Module: dmem_mmio_responder
// PURPOSE
// Data-side responder for the single-cycle MIPS core: the memory end of the
// memwrite/aluout/writedata/readdata interface. Decodes each access to a
// word RAM or memory-mapped peripherals: a countdown timer with FSM and IRQ,
// plus an 8-bit LED register. Sits beside imem at top level; reads are
// combinational so the core completes a lw in one cycle.
// PARAMETERS
// RAM_WORDS  64  RAM depth in 32-bit words (power of 2, >=4)
// TIMER_W    32  timer count/load width (<=32; reads zero-extend to 32)
// PORTS
// clk        in   1   rising-edge clock
// reset      in   1   asynchronous, active-high reset
// memwrite   in   1   write strobe for current access
// addr       in   32  byte address (core aluout); addr[1:0] ignored
// writedata  in   32  store data
// readdata   out  32  load data, combinational from addr
// irq        out  1   timer interrupt, level = STATUS.expired
// led        out  8   LED register contents
// BEHAVIOUR
// - Map (byte addr): RAM 0x0 .. RAM_WORDS*4-1, index addr[log2(RAM_WORDS)+1:2]
//   0xFFFFFF00 LOAD   RW  reload value (TIMER_W bits)
//   0xFFFFFF04 COUNT  RO  current count; writes ignored
//   0xFFFFFF08 CTRL   RW  bit0 enable, bit1 autoreload, others read 0
//   0xFFFFFF0C STATUS R/W1C  bit0 expired
//   0xFFFFFF10 LED    RW  bits[7:0]
//   Any other addr: reads 0, writes ignored (no RAM aliasing above RAM).
// - Writes take effect on the rising clk edge when memwrite=1. Reads return
//   pre-edge state: a same-cycle write is not forwarded to readdata.
// - Reset (async, immediate): LOAD=0, COUNT=0, CTRL=0, STATUS=0, LED=0,
//   FSM=IDLE, irq=0. RAM contents are not reset. Writes are ignored while
//   reset is high. A reset mid-count abandons the count with no expiry.
// - Timer FSM, evaluated at each edge:
//   IDLE: COUNT holds. A CTRL write with enable=1 loads COUNT<=LOAD -> RUN.
//   RUN:  COUNT!=0: COUNT<=COUNT-1.
//         COUNT==0: expired<=1. If autoreload, COUNT<=LOAD and stay RUN.
//         Otherwise -> DONE with enable cleared.
//   DONE: COUNT holds 0. A CTRL write with enable=1 reloads -> RUN.
//   Any state: a CTRL write with enable=0 -> IDLE and COUNT holds.
//   A CTRL write with enable=1 in RUN restarts the timer (COUNT<=LOAD).
// - Period is LOAD+1 cycles. LOAD=0 expires on the first edge after enable.
// - A LOAD write during RUN does not change COUNT; it applies at next reload.
// - STATUS: writing 1 to bit0 clears expired. If the clear and the set occur
//   on the same edge, set wins. irq follows expired, registered, no latency.
// - Arithmetic: COUNT is TIMER_W unsigned. It never decrements below 0.
//   Upper writedata bits beyond TIMER_W, or beyond 8 for LED, are dropped.
// TESTING
// 1 RAM: sw 0xDEADBEEF @0x8, then lw @0x8 -> 0xDEADBEEF. lw @0x0 after write
//   @0x4 leaves word 0 unchanged. Write @0x100 (RAM_WORDS=64) -> no RAM change.
// 2 One-shot: LOAD=3, CTRL=1 at edge E. COUNT reads 3,2,1,0 at E..E+3.
//   expired=irq=1 after E+4. CTRL reads 0. COUNT stays 0 for 10 cycles.
// 3 Autoreload: LOAD=2, CTRL=3. irq set at E+3 and every 3 cycles after,
//   with W1C between pulses. Clear on the same edge as expiry -> irq stays 1.
// 4 LOAD=0 with CTRL=1 -> expired after exactly 1 edge, FSM in DONE.
// 5 Mid-run: LOAD=10 running, write LOAD=4 -> COUNT continues 10-count.
//   CTRL=0 at COUNT=6 -> holds 6. Reset pulse -> all regs 0, irq 0 async.
// 6 Decode: LED write 0x1A5 -> led=0xA5. Read 0xFFFFFF14 -> 0.
//   Write COUNT -> unchanged.

Source files
------------

// File: rtl/dmem_mmio_responder_if.sv
// rtl/dmem_mmio_responder_if.sv - data-memory bus between the core and the memory-side responder
//
// Signals:
//   memwrite   write strobe for the current access
//   addr       byte address (core aluout)
//   writedata  store data
//   readdata   load data, combinational from addr
// Modports:
//   master  core side (drives memwrite/addr/writedata)
//   slave   responder side (drives readdata)

interface dmem_mmio_responder_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output memwrite,
        output addr,
        output writedata,
        input  readdata
    );

    modport slave (
        input  memwrite,
        input  addr,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - word RAM plus countdown timer and LED register on the data bus
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    dmem_mmio_responder_if.slave (memwrite, addr, writedata in; readdata out)
//   irq    timer interrupt, level of STATUS.expired
//   led    LED register contents
//
// Map (byte address, addr[1:0] ignored):
//   0x0 .. RAM_WORDS*4-1  RAM
//   0xFFFFFF00 LOAD, 0xFFFFFF04 COUNT (RO), 0xFFFFFF08 CTRL,
//   0xFFFFFF0C STATUS (W1C), 0xFFFFFF10 LED; anything else reads 0.

module dmem_mmio_responder #(
    parameter int RAM_WORDS = 64,
    parameter int TIMER_W   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    dmem_mmio_responder_if.slave        bus,
    output logic                        irq,
    output logic [7:0]                  led
);

    localparam int AW = $clog2(RAM_WORDS);

    // Word addresses (byte address >> 2) of the peripheral registers.
    localparam logic [29:0] W_LOAD   = 30'h3FFF_FFC0;
    localparam logic [29:0] W_COUNT  = 30'h3FFF_FFC1;
    localparam logic [29:0] W_CTRL   = 30'h3FFF_FFC2;
    localparam logic [29:0] W_STATUS = 30'h3FFF_FFC3;
    localparam logic [29:0] W_LED    = 30'h3FFF_FFC4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [29:0]   waddr;
    logic          in_ram;
    logic [AW-1:0] ram_idx;
    logic          wr_ram, wr_load, wr_ctrl, wr_status, wr_led;

    assign waddr   = bus.addr[31:2];
    // Every bit above the RAM index must be zero, so nothing aliases into RAM.
    assign in_ram  = (bus.addr[31:AW+2] == '0);
    assign ram_idx = bus.addr[AW+1:2];

    assign wr_ram    = bus.memwrite && in_ram;
    assign wr_load   = bus.memwrite && (waddr == W_LOAD);
    assign wr_ctrl   = bus.memwrite && (waddr == W_CTRL);
    assign wr_status = bus.memwrite && (waddr == W_STATUS);
    assign wr_led    = bus.memwrite && (waddr == W_LED);

    // ------------------------------------------------------------------
    // RAM (not reset; writes suppressed while reset is asserted)
    // ------------------------------------------------------------------
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (!reset && wr_ram) begin
            ram[ram_idx] <= bus.writedata;
        end
    end

    // ------------------------------------------------------------------
    // Timer and LED registers
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [TIMER_W-1:0] load_q;
    logic [TIMER_W-1:0] count_q, count_d;
    logic               en_q, en_d;
    logic               ar_q, ar_d;
    logic               expired_q, expired_d;
    logic [7:0]         led_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            load_q    <= '0;
            count_q   <= '0;
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            expired_q <= 1'b0;
            led_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            en_q      <= en_d;
            ar_q      <= ar_d;
            expired_q <= expired_d;
            if (wr_load) begin
                load_q <= bus.writedata[TIMER_W-1:0];
            end
            if (wr_led) begin
                led_q <= bus.writedata[7:0];
            end
        end
    end

    // A CTRL write always takes priority over the running countdown: it
    // either restarts from LOAD (enable=1) or parks in IDLE (enable=0).
    // Reloads use the pre-edge LOAD, so a LOAD write only lands next time.
    always_comb begin
        logic exp_set;
        state_d = state_q;
        count_d = count_q;
        en_d    = en_q;
        ar_d    = ar_q;
        exp_set = 1'b0;

        if (wr_ctrl) begin
            en_d = bus.writedata[0];
            ar_d = bus.writedata[1];
            if (bus.writedata[0]) begin
                count_d = load_q;
                state_d = S_RUN;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (count_q != '0) begin
                        count_d = count_q - TIMER_W'(1);
                    end else begin
                        exp_set = 1'b1;
                        if (ar_q) begin
                            count_d = load_q;
                        end else begin
                            state_d = S_DONE;
                            en_d    = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        // Set beats a simultaneous write-1-to-clear.
        expired_d = exp_set | (expired_q & ~(wr_status & bus.writedata[0]));
    end

    // ------------------------------------------------------------------
    // Read mux (pre-edge state, no write forwarding)
    // ------------------------------------------------------------------
    always_comb begin
        bus.readdata = 32'h0;
        if (in_ram) begin
            bus.readdata = ram[ram_idx];
        end else begin
            case (waddr)
                W_LOAD:   bus.readdata = 32'(load_q);
                W_COUNT:  bus.readdata = 32'(count_q);
                W_CTRL:   bus.readdata = {30'h0, ar_q, en_q};
                W_STATUS: bus.readdata = {31'h0, expired_q};
                W_LED:    bus.readdata = {24'h0, led_q};
                default:  bus.readdata = 32'h0;
            endcase
        end
    end

    assign irq = expired_q;
    assign led = led_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb/tb_dmem_mmio_responder.sv - randomized check of dmem_mmio_responder against a behavioural model

module tb_dmem_mmio_responder;

    localparam int RAM_WORDS = 64;
    localparam int TIMER_W   = 32;

    localparam logic [31:0] A_LOAD   = 32'hFFFF_FF00;
    localparam logic [31:0] A_COUNT  = 32'hFFFF_FF04;
    localparam logic [31:0] A_CTRL   = 32'hFFFF_FF08;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FF0C;
    localparam logic [31:0] A_LED    = 32'hFFFF_FF10;

    logic       clk = 1'b0;
    logic       reset;
    logic       irq;
    logic [7:0] led;

    dmem_mmio_responder_if bus ();

    dmem_mmio_responder #(
        .RAM_WORDS (RAM_WORDS),
        .TIMER_W   (TIMER_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq),
        .led   (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: timer described as "running or not" plus counters.
    // ------------------------------------------------------------------
    logic [31:0] m_ram [RAM_WORDS];
    logic [31:0] m_load, m_count;
    bit          m_en, m_ar, m_exp, m_run;
    logic [7:0]  m_led;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (wa < RAM_WORDS * 4) return m_ram[wa / 4];
        if (wa == A_LOAD)   return m_load;
        if (wa == A_COUNT)  return m_count;
        if (wa == A_CTRL)   return {30'h0, m_ar, m_en};
        if (wa == A_STATUS) return {31'h0, m_exp};
        if (wa == A_LED)    return {24'h0, m_led};
        return 32'h0;
    endfunction

    task automatic m_reset();
        m_load = 0; m_count = 0; m_en = 0; m_ar = 0; m_exp = 0; m_run = 0; m_led = 0;
    endtask

    task automatic m_edge(input bit we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] wa;
        bit          fired;
        wa    = {a[31:2], 2'b00};
        fired = 0;
        // Timer step uses the LOAD value from before this edge.
        if (we && wa == A_CTRL) begin
            m_en  = wd[0];
            m_ar  = wd[1];
            m_run = wd[0];
            if (wd[0]) m_count = m_load;
        end else if (m_run) begin
            if (m_count > 0) begin
                m_count = m_count - 1;
            end else begin
                fired = 1;
                if (m_ar) m_count = m_load;
                else begin
                    m_run = 0;
                    m_en  = 0;
                end
            end
        end
        if (we && wa == A_STATUS && wd[0]) m_exp = 0;
        if (fired) m_exp = 1;
        if (we) begin
            if (wa < RAM_WORDS * 4) m_ram[wa / 4] = wd;
            if (wa == A_LOAD) m_load = wd;
            if (wa == A_LED)  m_led  = wd[7:0];
        end
    endtask

    // One bus cycle: drive, check pre-edge view, then advance the model.
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
        @(negedge clk);
        bus.memwrite  = we;
        bus.addr      = a;
        bus.writedata = wd;
        #1;
        rd = bus.readdata;
        chk("readdata", rd, m_read(a));
        chk("irq", {31'h0, irq}, {31'h0, m_exp});
        chk("led", {24'h0, led}, {24'h0, m_led});
        @(posedge clk);
        m_edge(we, a, wd);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        bus.memwrite = 1'b0;
        bus.addr     = A_COUNT;
        #2 reset = 1'b1;
        #1;
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_led", {24'h0, led}, 32'h0);
        chk("rst_count", bus.readdata, 32'h0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2: return $urandom_range(0, RAM_WORDS * 4 - 1);
            3:       return RAM_WORDS * 4 + $urandom_range(0, 1023);
            4:       return A_LOAD;
            5:       return A_COUNT;
            6:       return A_CTRL;
            7:       return A_STATUS;
            8:       return A_LED;
            default: return ($urandom_range(0, 1) == 0) ? 32'hFFFF_FF14 : ($urandom | 32'h8000_0000);
        endcase
    endfunction

    logic [31:0] rd;

    initial begin
        reset         = 1'b1;
        bus.memwrite  = 1'b0;
        bus.addr      = A_COUNT;
        bus.writedata = 32'h0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_led", {24'h0, led}, 32'h0);
        chk("reset_count", bus.readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < RAM_WORDS; i++) step(1'b1, i * 4, $urandom, rd);

        // RAM: store/load, neighbour untouched, no aliasing above RAM.
        step(1'b1, 32'h8, 32'hDEAD_BEEF, rd);
        step(1'b0, 32'h8, 32'h0, rd);
        chk("ram_lw8", rd, 32'hDEAD_BEEF);
        step(1'b1, 32'h0, 32'h1111_1111, rd);
        step(1'b1, 32'h4, 32'h2222_2222, rd);
        step(1'b1, 32'h100, 32'h3333_3333, rd);
        step(1'b0, 32'h0, 32'h0, rd);
        chk("ram_word0", rd, 32'h1111_1111);
        step(1'b0, 32'h100, 32'h0, rd);
        chk("ram_above", rd, 32'h0);

        // One-shot: LOAD=3, CTRL=1 at edge E.
        step(1'b1, A_LOAD, 32'd3, rd);
        step(1'b1, A_CTRL, 32'd1, rd);
        for (int k = 3; k >= 0; k--) begin
            step(1'b0, A_COUNT, 32'h0, rd);
            chk("oneshot_count", rd, k);
        end
        step(1'b0, A_STATUS, 32'h0, rd);
        chk("oneshot_status", rd, 32'h1);
        chk("oneshot_irq", {31'h0, irq}, 32'h1);
        step(1'b0, A_CTRL, 32'h0, rd);
        chk("oneshot_ctrl", rd, 32'h0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, A_COUNT, 32'h0, rd);
            chk("oneshot_hold0", rd, 32'h0);
        end
        step(1'b1, A_STATUS, 32'h1, rd);

        // Autoreload with clear on the same edge as expiry.
        step(1'b1, A_LOAD, 32'd2, rd);
        step(1'b1, A_CTRL, 32'd3, rd);
        step(1'b0, A_COUNT, 32'h0, rd);
        chk("auto_count2", rd, 32'd2);
        step(1'b0, A_COUNT, 32'h0, rd);
        step(1'b1, A_STATUS, 32'h1, rd);
        step(1'b0, A_STATUS, 32'h0, rd);
        chk("auto_set_wins", rd, 32'h1);
        step(1'b1, A_STATUS, 32'h1, rd);
        step(1'b0, A_STATUS, 32'h0, rd);
        chk("auto_cleared", rd, 32'h0);
        step(1'b0, A_COUNT, 32'h0, rd);
        step(1'b0, A_STATUS, 32'h0, rd);
        chk("auto_reexpire", rd, 32'h1);

        // LOAD=0: expires after one edge and stops.
        step(1'b1, A_CTRL, 32'h0, rd);
        step(1'b1, A_STATUS, 32'h1, rd);
        step(1'b1, A_LOAD, 32'h0, rd);
        step(1'b1, A_CTRL, 32'h1, rd);
        step(1'b0, A_STATUS, 32'h0, rd);
        chk("load0_not_yet", rd, 32'h0);
        step(1'b0, A_STATUS, 32'h0, rd);
        chk("load0_expired", rd, 32'h1);
        step(1'b0, A_CTRL, 32'h0, rd);
        chk("load0_done_ctrl", rd, 32'h0);

        // Mid-run LOAD write and disable hold.
        step(1'b1, A_LOAD, 32'd10, rd);
        step(1'b1, A_CTRL, 32'h1, rd);
        step(1'b1, A_LOAD, 32'd4, rd);
        step(1'b0, A_COUNT, 32'h0, rd);
        chk("midrun_count9", rd, 32'd9);
        step(1'b0, A_COUNT, 32'h0, rd);
        step(1'b0, A_COUNT, 32'h0, rd);
        step(1'b1, A_CTRL, 32'h0, rd);
        step(1'b0, A_COUNT, 32'h0, rd);
        chk("midrun_hold6", rd, 32'd6);
        step(1'b1, A_COUNT, 32'd99, rd);
        step(1'b0, A_COUNT, 32'h0, rd);
        chk("count_ro", rd, 32'd6);
        pulse_reset();

        // Decode: LED truncation and unmapped read.
        step(1'b1, A_LED, 32'h1A5, rd);
        #1;
        chk("led_trunc", {24'h0, led}, 32'hA5);
        step(1'b0, 32'hFFFF_FF14, 32'h0, rd);
        chk("unmapped", rd, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, wd;
            bit          we;
            a  = rand_addr();
            we = ($urandom_range(0, 1) == 1);
            wd = $urandom;
            if ({a[31:2], 2'b00} == A_LOAD) wd = $urandom_range(0, 6);
            if ({a[31:2], 2'b00} == A_CTRL && $urandom_range(0, 3) != 0) wd = wd | 32'h1;
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else step(we, a, wd, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
